// File: rtl/instruction_sequencer.sv
// instruction_sequencer: issues words from a small program memory to the
// Processor's 13-bit instruction input, holding each for HOLD_CYCLES clocks.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   prog_we_i/addr_i/data_i program memory write port (accepted in IDLE only)
//   prog_len_i              words to run, latched on an accepted start
//   start_i, abort_i        run request (level, IDLE only) / stop current run
//   instruction_o           sanitised word presented to the Processor
//   issue_o                 pulse in the first cycle of each new word
//   pc_o                    index of the word currently presented
//   busy_o, done_o          run in progress / one-cycle normal completion
module instruction_sequencer #(
  parameter int unsigned PROG_DEPTH  = 16,
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned AW          = $clog2(PROG_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [12:0]   prog_data_i,
  input  logic [AW:0]   prog_len_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [12:0]   instruction_o,
  output logic          issue_o,
  output logic [AW-1:0] pc_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [LW-1:0] len_q;
  logic [12:0]   instr_q;
  logic          issue_q;
  logic [AW-1:0] pc_q;
  logic          busy_q;
  logic          done_q;

  logic [12:0]   mem_q [PROG_DEPTH];

  logic [LW-1:0] len_d;
  logic [12:0]   first_word_d;
  logic [12:0]   next_word_d;
  logic          last_word_d;

  // Vector ops carry no operands, so their low 11 bits are forced to zero.
  function automatic logic [12:0] sanitise(input logic [12:0] w);
    return w[12] ? {w[12:11], 11'b0} : w;
  endfunction

  assign len_d        = (prog_len_i > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : prog_len_i;
  assign first_word_d = sanitise(mem_q[0]);
  assign next_word_d  = sanitise(mem_q[pc_q + AW'(1)]);
  assign last_word_d  = (LW'(pc_q) == (len_q - LW'(1)));

  // Program memory: writable only while idle, untouched by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && prog_we_i && (state_q == ST_IDLE)) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      instr_q <= '0;
      issue_q <= 1'b0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      issue_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_q <= len_d;
            if (len_d == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_HOLD;
              busy_q  <= 1'b1;
              pc_q    <= '0;
              instr_q <= first_word_d;
              cnt_q   <= CW'(HOLD_CYCLES - 1);
              issue_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (!last_word_d) begin
            pc_q    <= pc_q + AW'(1);
            instr_q <= next_word_d;
            cnt_q   <= CW'(HOLD_CYCLES - 1);
            issue_q <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instruction_o = instr_q;
  assign issue_o       = issue_q;
  assign pc_o          = pc_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: two instances (hold 10 and hold 1) share
// stimulus; a timeline model predicts every output each cycle.
module tb_instruction_sequencer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [12:0]   prog_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;

  logic [12:0]   instr_w [2];
  logic          issue_w [2];
  logic [AW-1:0] pc_w    [2];
  logic          busy_w  [2];
  logic          done_w  [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instruction_sequencer #(.PROG_DEPTH(DEPTH), .HOLD_CYCLES(10)) u_a (
    .clk_i(clk), .rst_i(rst), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
    .prog_data_i(prog_data), .prog_len_i(prog_len), .start_i(start), .abort_i(abort),
    .instruction_o(instr_w[0]), .issue_o(issue_w[0]), .pc_o(pc_w[0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]));

  instruction_sequencer #(.PROG_DEPTH(DEPTH), .HOLD_CYCLES(1)) u_b (
    .clk_i(clk), .rst_i(rst), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
    .prog_data_i(prog_data), .prog_len_i(prog_len), .start_i(start), .abort_i(abort),
    .instruction_o(instr_w[1]), .issue_o(issue_w[1]), .pc_o(pc_w[1]),
    .busy_o(busy_w[1]), .done_o(done_w[1]));

  // Model: a run is a timeline of len*hold cycles; word index = elapsed / hold.
  int          hold [2] = '{10, 1};
  bit          m_run  [2];
  bit          m_done [2];
  int          m_t    [2];
  int          m_len  [2];
  logic [12:0] m_instr[2];
  int          m_pc   [2];
  logic [12:0] m_mem  [2][DEPTH];

  function automatic logic [12:0] san(input logic [12:0] w);
    if (w[12]) return {w[12:11], 11'b0};
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_done[i] = 0; m_t[i] = 0; m_len[i] = 0;
      m_instr[i] = '0; m_pc[i] = 0;
      for (int a = 0; a < DEPTH; a++) m_mem[i][a] = '0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_done[i] = 0; m_t[i] = 0; m_instr[i] = '0; m_pc[i] = 0;
      end else if (m_run[i]) begin
        if (abort) begin
          m_run[i] = 0;
        end else begin
          m_t[i]++;
          if (m_t[i] == m_len[i] * hold[i]) begin
            m_run[i]  = 0;
            m_done[i] = 1;
          end else begin
            m_pc[i]    = m_t[i] / hold[i];
            m_instr[i] = san(m_mem[i][m_pc[i]]);
          end
        end
      end else if (m_done[i]) begin
        m_done[i] = 0;
      end else begin
        if (start) begin
          int l;
          l = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
          if (l == 0) begin
            m_done[i] = 1;
          end else begin
            m_run[i] = 1; m_t[i] = 0; m_len[i] = l; m_pc[i] = 0;
            m_instr[i] = san(m_mem[i][0]);
          end
        end
        if (prog_we) m_mem[i][prog_addr] = prog_data;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("instr[%0d]", i), 32'(instr_w[i]), 32'(m_instr[i]));
        check($sformatf("issue[%0d]", i), 32'(issue_w[i]),
              32'(m_run[i] && (m_t[i] % hold[i] == 0)));
        check($sformatf("pc[%0d]", i), 32'(pc_w[i]), 32'(m_pc[i]));
        check($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_run[i]));
        check($sformatf("done[%0d]", i), 32'(done_w[i]), 32'(m_done[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [12:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic go(input int len);
    prog_len = (AW+1)'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic lit_a(input string name, input logic [12:0] ins, input bit iss,
                       input int pc, input bit bsy, input bit dn);
    check({name, ".instr"}, 32'(instr_w[0]), 32'(ins));
    check({name, ".issue"}, 32'(issue_w[0]), 32'(iss));
    check({name, ".pc"},    32'(pc_w[0]),    32'(pc));
    check({name, ".busy"},  32'(busy_w[0]),  32'(bsy));
    check({name, ".done"},  32'(done_w[0]),  32'(dn));
  endtask

  task automatic load_basic();
    wr(0, 13'h0000);
    wr(1, 13'h0200);
    wr(2, 13'h17FF);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    lit_a("reset", 13'h0000, 0, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) wr(i, 13'((i * 613) % 8192));

    // Basic three-word run
    load_basic();
    go(3);
    lit_a("basic.w0", 13'h0000, 1, 0, 1, 0);
    adv(10);
    lit_a("basic.w1", 13'h0200, 1, 1, 1, 0);
    adv(10);
    lit_a("basic.w2", 13'h1000, 1, 2, 1, 0);
    adv(9);
    lit_a("basic.tail", 13'h1000, 0, 2, 1, 0);
    adv(1);
    lit_a("basic.done", 13'h1000, 0, 2, 0, 1);
    adv(1);
    lit_a("basic.idle", 13'h1000, 0, 2, 0, 0);

    // Sanitised multiply, verbatim store
    wr(0, 13'h1FFF);
    wr(1, 13'h0BFF);
    go(2);
    lit_a("san.mul", 13'h1800, 1, 0, 1, 0);
    adv(10);
    lit_a("san.store", 13'h0BFF, 1, 1, 1, 0);
    adv(10);
    lit_a("san.done", 13'h0BFF, 0, 1, 0, 1);
    adv(1);

    // Zero length
    go(0);
    lit_a("len0", 13'h0BFF, 0, 1, 0, 1);
    adv(1);

    // Over-long length clamps to full memory
    for (int i = 0; i < DEPTH; i++) wr(i, 13'h0800 | 13'(i));
    go(31);
    adv(150);
    lit_a("len31.last", 13'h080F, 1, 15, 1, 0);
    adv(10);
    lit_a("len31.done", 13'h080F, 0, 15, 0, 1);
    adv(1);

    // Abort in cycle 15 of a three-word run, then rerun
    load_basic();
    go(3);
    adv(14);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    lit_a("abort", 13'h0200, 0, 1, 0, 0);
    adv(20);
    lit_a("abort.nodone", 13'h0200, 0, 1, 0, 0);
    go(3);
    lit_a("rerun", 13'h0000, 1, 0, 1, 0);
    adv(31);

    // Mid-run start and write are ignored
    go(3);
    adv(3);
    start = 1'b1; prog_we = 1'b1; prog_addr = AW'(1); prog_data = 13'h1FFF;
    tick();
    start = 1'b0; prog_we = 1'b0;
    adv(40);
    go(3);
    adv(10);
    lit_a("ignored.readback", 13'h0200, 1, 1, 1, 0);
    adv(25);

    // Reset mid-run
    go(3);
    adv(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    lit_a("rst.mid", 13'h0000, 0, 0, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 499) == 0);
      abort     = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 19) == 0);
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = AW'($urandom_range(0, DEPTH - 1));
      prog_data = 13'($urandom);
      prog_len  = (AW+1)'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0; prog_we = 1'b0;
    adv(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
